// File: rtl/cpu_stage_pipe_buffer.sv
// ============================================================================
// Module   : cpu_stage_pipe_buffer
// Brief    : Generic FIFO buffer between CPU pipeline stages with a
//            valid/allowin handshake on each side.
//            Optional same-cycle bypass when empty: CPU_STAGE_BUFFER_BYPASS_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_stage_pipe_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_allowin,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_allowin,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] C_FULL     = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] C_OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_depth_illegal
            $error("cpu_stage_pipe_buffer: DEPTH must be within 1..16");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_storage [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [OCC_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_bypass_open;
    logic w_bypass_take;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + C_PTR_ONE;
    endfunction

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

`ifdef CPU_STAGE_BUFFER_BYPASS_EN
    // Empty buffer forwards the upstream beat; it is only stored if refused.
    assign w_bypass_open = w_empty & ~flush & ~reset;
    assign w_bypass_take = w_bypass_open & in_valid & out_allowin;
`else
    assign w_bypass_open = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign in_allowin = ~w_full;
    assign w_push     = in_valid & ~w_full & ~w_bypass_take;
    assign w_pop      = ~w_empty & out_allowin;
    assign w_wr_en    = w_push & ~flush & ~reset;

    assign out_valid  = ~w_empty | (w_bypass_open & in_valid);
    assign occupancy  = r_count;

    always_comb begin
        out_data = '0;
        if (!w_empty) begin
            out_data = r_storage[r_rd_ptr];
        end else if (w_bypass_open && in_valid) begin
            out_data = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_OCC_ONE;
                2'b01:   r_count <= r_count - C_OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload array is deliberately left uncleared by reset and flush.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_storage[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (r_count <= C_FULL)
                else $error("cpu_stage_pipe_buffer: occupancy exceeds DEPTH");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_stage_pipe_buffer.sv
// ============================================================================
// Module   : tb_cpu_stage_pipe_buffer
// Brief    : Self-checking bench; three buffers (DEPTH 1, 2, 3) share stimulus
//            and are compared against queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_stage_pipe_buffer;

`ifdef CPU_STAGE_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_allowin;

    logic        ia1, ia2, ia3;
    logic        ov1, ov2, ov3;
    logic [31:0] od1, od2, od3;
    logic [0:0]  oc1;
    logic [1:0]  oc2, oc3;

    int errors = 0;
    int checks = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    always #5 clock = ~clock;

    cpu_stage_pipe_buffer #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allowin(ia1), .in_data(in_data),
        .out_valid(ov1), .out_allowin(out_allowin), .out_data(od1),
        .occupancy(oc1));

    cpu_stage_pipe_buffer #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allowin(ia2), .in_data(in_data),
        .out_valid(ov2), .out_allowin(out_allowin), .out_data(od2),
        .occupancy(oc2));

    cpu_stage_pipe_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u_d3 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allowin(ia3), .in_data(in_data),
        .out_valid(ov3), .out_allowin(out_allowin), .out_data(od3),
        .occupancy(oc3));

    // Reference models: plain FIFO queues updated on each rising edge.
    always @(posedge clock) begin : m1
        int  sz;
        bit  take;
        sz = q1.size();
        if (reset || flush) q1.delete();
        else begin
            take = BYP && sz == 0 && in_valid && out_allowin;
            if (sz != 0 && out_allowin) void'(q1.pop_front());
            if (in_valid && sz != 1 && !take) q1.push_back(in_data);
        end
    end

    always @(posedge clock) begin : m2
        int  sz;
        bit  take;
        sz = q2.size();
        if (reset || flush) q2.delete();
        else begin
            take = BYP && sz == 0 && in_valid && out_allowin;
            if (sz != 0 && out_allowin) void'(q2.pop_front());
            if (in_valid && sz != 2 && !take) q2.push_back(in_data);
        end
    end

    always @(posedge clock) begin : m3
        int  sz;
        bit  take;
        sz = q3.size();
        if (reset || flush) q3.delete();
        else begin
            take = BYP && sz == 0 && in_valid && out_allowin;
            if (sz != 0 && out_allowin) void'(q3.pop_front());
            if (in_valid && sz != 3 && !take) q3.push_back(in_data);
        end
    end

    function automatic bit exp_valid(int sz);
        return (sz != 0) || (BYP && in_valid && !reset && !flush);
    endfunction

    function automatic logic [31:0] exp_data(int sz, logic [31:0] head);
        return (sz != 0) ? head : in_data;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
        in_data = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99;
        out_allowin = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (oc2 !== 2'd0 || ov2 !== 1'b0 || ia2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: occ=%0d valid=%b allowin=%b, want 0 0 1", oc2, ov2, ia2);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (oc1 !== 1'd0 || ov1 !== 1'b0 || ia1 !== 1'b1 || od1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_d1: occ=%0d valid=%b allowin=%b data=%h, want 0 0 1 0", oc1, ov1, ia1, od1);
        end
        checks++;
        if (oc3 !== 2'd0 || ov3 !== 1'b0 || ia3 !== 1'b1 || od3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_d3: occ=%0d valid=%b allowin=%b data=%h, want 0 0 1 0", oc3, ov3, ia3, od3);
        end
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA; out_allowin = 1'b0;
        tick();
        in_data = 32'hB;
        #1;
        checks++;
        if (oc2 !== 2'd1 || od2 !== 32'hA || ov2 !== 1'b1) begin
            errors++;
            $display("FAIL fill_first: occ=%0d data=%h valid=%b, want 1 a 1", oc2, od2, ov2);
        end
        tick();
        in_data = 32'hF;
        #1;
        checks++;
        if (oc2 !== 2'd2 || ia2 !== 1'b0 || od2 !== 32'hA) begin
            errors++;
            $display("FAIL fill_full: occ=%0d allowin=%b data=%h, want 2 0 a", oc2, ia2, od2);
        end
        tick();
        #1;
        checks++;
        if (oc2 !== 2'd2 || od2 !== 32'hA) begin
            errors++;
            $display("FAIL fill_refused: occ=%0d data=%h, want 2 a", oc2, od2);
        end
    endtask

    task automatic test_drain();
        in_valid = 1'b0; out_allowin = 1'b1;
        #1;
        checks++;
        if (od2 !== 32'hA || oc2 !== 2'd2) begin
            errors++;
            $display("FAIL drain_first: data=%h occ=%0d, want a 2", od2, oc2);
        end
        tick();
        #1;
        checks++;
        if (od2 !== 32'hB || oc2 !== 2'd1 || ov2 !== 1'b1) begin
            errors++;
            $display("FAIL drain_second: data=%h occ=%0d valid=%b, want b 1 1", od2, oc2, ov2);
        end
        tick();
        #1;
        checks++;
        if (oc2 !== 2'd0 || ov2 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: occ=%0d valid=%b, want 0 0", oc2, ov2);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int          next;
        bit          bad;
        do_reset();
        next = 1;
        bad  = 1'b0;
        for (int cyc = 0; cyc < 60 && got.size() < 7; cyc++) begin
            in_valid    = (next <= 7);
            in_data     = 32'(next);
            out_allowin = (cyc % 2 == 0);
            #1;
            if (ov3 && out_allowin) got.push_back(od3);
            if (in_valid && ia3) next++;
            if (ov3 !== exp_valid(q3.size())
                || (ov3 && od3 !== exp_data(q3.size(), q3.size() != 0 ? q3[0] : 32'h0)))
                bad = 1'b1;
            tick();
        end
        in_valid = 1'b0; out_allowin = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wrap_model: per-cycle outputs diverged from reference");
        end
        checks++;
        if (got.size() != 7) begin
            errors++;
            $display("FAIL wrap_count: got %0d outputs, want 7", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h, want %h", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_flush();
        bit leaked;
        do_reset();
        in_valid = 1'b1; out_allowin = 1'b0;
        in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        flush = 1'b1; in_data = 32'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (oc2 !== 2'd0 || ov2 !== 1'b0 || ia2 !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: occ=%0d valid=%b allowin=%b, want 0 0 1", oc2, ov2, ia2);
        end
        leaked = 1'b0;
        out_allowin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ov2 !== 1'b0) leaked = 1'b1;
            tick();
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL flush_drop: flushed payload appeared at output, want none");
        end
        out_allowin = 1'b0;
    endtask

    task automatic test_bypass();
        logic       want_v;
        logic [1:0] want_occ;
        do_reset();
        in_valid = 1'b1; in_data = 32'h5; out_allowin = 1'b1;
        #1;
        want_v = BYP;
        checks++;
        if (ov2 !== want_v || (want_v && od2 !== 32'h5)) begin
            errors++;
            $display("FAIL bypass_same_cycle: valid=%b data=%h, want valid=%b data=5", ov2, od2, want_v);
        end
        tick();
        in_valid = 1'b0; out_allowin = 1'b0;
        #1;
        want_v   = !BYP;
        want_occ = BYP ? 2'd0 : 2'd1;
        checks++;
        if (ov2 !== want_v || oc2 !== want_occ || (want_v && od2 !== 32'h5)) begin
            errors++;
            $display("FAIL bypass_next_cycle: valid=%b occ=%0d data=%h, want valid=%b occ=%0d data=5",
                     ov2, oc2, od2, want_v, want_occ);
        end
        tick();
    endtask

    task automatic test_random();
        int          sz   [3];
        logic [31:0] head [3];
        int          occ  [3];
        logic        vld  [3];
        logic        alw  [3];
        logic [31:0] dat  [3];
        int          dep  [3];
        do_reset();
        dep = '{1, 2, 3};
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            out_allowin = ($urandom_range(0, 2) != 0);
            in_data     = $urandom;
            #1;
            sz   = '{q1.size(), q2.size(), q3.size()};
            head = '{q1.size() != 0 ? q1[0] : 32'h0,
                     q2.size() != 0 ? q2[0] : 32'h0,
                     q3.size() != 0 ? q3[0] : 32'h0};
            occ  = '{int'(oc1), int'(oc2), int'(oc3)};
            vld  = '{ov1, ov2, ov3};
            alw  = '{ia1, ia2, ia3};
            dat  = '{od1, od2, od3};
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (occ[k] != sz[k] || alw[k] !== (sz[k] != dep[k]) || vld[k] !== exp_valid(sz[k])
                    || (vld[k] && dat[k] !== exp_data(sz[k], head[k]))) begin
                    errors++;
                    $display("FAIL random_d%0d cyc %0d: occ=%0d allowin=%b valid=%b data=%h, want occ=%0d allowin=%b valid=%b data=%h",
                             dep[k], cyc, occ[k], alw[k], vld[k], dat[k], sz[k], sz[k] != dep[k],
                             exp_valid(sz[k]), exp_data(sz[k], head[k]));
                end
            end
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        out_allowin = 1'b0;
        tick();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
